bitserial_mac_acc: RTL and testbench
====================================

// Module: bitserial_mac_acc
// PURPOSE
//  Receive-side datapath of the bit-serial weighted-sum interface.
//  Each frame is BEATS consecutive input_valid cycles of N_IN partial products,
//  MSB weight first. Beat b carries weight[k]*in[k][BEATS-1-b] per lane.
//  The block sums the lanes on every beat and shift-accumulates the beats.
//  It then presents the frame's weighted sum on Output with a one-cycle out_valid pulse.
// PARAMETERS
//  N_IN   32  lanes per beat (Input_1..Input_N_IN)
//  IN_W   4   bits per lane
//  BEATS  4   beats per frame (input bit-planes)
//  OUT_W  13  result width; must be >= clog2(N_IN*(2^IN_W-1)*(2^BEATS-1)+1)
// PORTS
//  clk          in   1     clock; all state changes on the rising edge
//  rst          in   1     asynchronous, active-high reset
//  input_valid  in   1     beat qualifier; high for exactly BEATS cycles per frame
//  Input_1..32  in   4 ea  lane partial products; unsigned; don't-care when input_valid=0
//  out_valid    out  1     one-cycle result strobe
//  Output       out  13    unsigned weighted sum; 0 whenever out_valid=0
// BEHAVIOUR
//  Reset: out_valid=0, Output=0, beat_cnt=0, column-sum and accumulator regs=0.
//    Assertion is asynchronous. Release takes effect at the first clk edge after rst falls.
//  Stage 1, on an edge with input_valid=1:
//    col_sum (9b) <= unsigned sum of the 32 lanes (max 480); s1_vld <= 1.
//    s1_first <= (beat_cnt==0); s1_last <= (beat_cnt==BEATS-1).
//    beat_cnt <= beat_cnt+1, wrapping BEATS-1 -> 0.
//  Stage 2, on an edge with s1_vld=1:
//    acc <= (s1_first ? 0 : acc<<1) + col_sum, computed at OUT_W bits.
//    No overflow is possible at the defaults: the maximum is 480*15 = 7200 < 8192.
//  Output register:
//    If s1_vld and s1_last, then Output <= that same final acc value and out_valid <= 1.
//    Otherwise Output <= 0 and out_valid <= 0.
//  Latency: the last beat of a frame is sampled at edge E. Output/out_valid are valid E+1..E+2.
//    out_valid is high for exactly one cycle per complete frame.
//  States: IDLE (beat_cnt==0) and RECV (beat_cnt 1..BEATS-1).
//    IDLE -> RECV on input_valid.
//    RECV -> IDLE after beat BEATS-1, or on abort.
//  Back-to-back: input_valid may stay high for k*BEATS cycles and produce k frames.
//    The out_valid pulses are then exactly BEATS cycles apart.
//    No bubble is required between frames.
//  Abort: input_valid=0 while in RECV (1..BEATS-1 beats received) -> beat_cnt <= 0.
//    The partial frame is discarded and produces no out_valid.
//    A later beat starts a new frame and clears acc.
//  A new frame's stage-1/2 activity overlaps the previous result cycle without corruption.
//  Reset mid-frame: the partial frame is lost. Any pending out_valid is cancelled immediately.
//  Input lanes are never sampled when input_valid=0. X on those lanes must not propagate.
// CONFIGURATION
//  BSMAC_FRAME_ERR_EN defined:
//    Adds an output port frame_err (1b, reset 0).
//    frame_err pulses for one cycle, on the edge after an abort is detected.
//    out_valid behaviour is unchanged.
//  BSMAC_FRAME_ERR_EN undefined:
//    The port and its logic are absent. Aborts are discarded silently.
// TESTING
//  1 All 32 lanes = 15 on all 4 beats -> one out_valid pulse; Output = 7200.
//    The pulse falls 2 edges after the last beat.
//  2 All lanes = 0 for 4 beats -> out_valid pulse with Output = 0.
//    Output also stays 0 outside the pulse.
//  3 Only Input_1 = 1 on beat 0, all others 0 -> Output = 8.
//    Input_1 = 1 on beat 3 only -> Output = 1.
//  4 Two back-to-back frames over 8 valid cycles (all lanes 1; then all lanes 2):
//    -> 480 then 960, with the out_valid pulses 4 cycles apart.
//  5 A 2-beat frame with lanes 15, then input_valid=0, then a full all-1 frame:
//    -> exactly one pulse, Output = 480.
//    With BSMAC_FRAME_ERR_EN, frame_err pulses once.
//  6 rst asserted between beat 2 and beat 3:
//    -> outputs go to 0 immediately and no pulse follows.
//    A subsequent random frame matches the golden sum(in[k]*weight[k]).

Source files
------------

// File: rtl/bitserial_mac_acc.sv
// bitserial_mac_acc
//   Receive-side datapath of a bit-serial weighted-sum interface. A frame is
//   BEATS consecutive input_valid cycles. Each beat carries N_IN unsigned
//   partial products, with the MSB weight first. The lanes are summed every
//   beat (stage 1), and the beat sums are shift-accumulated (stage 2). The
//   frame's weighted sum is then presented on Output for one cycle,
//   qualified by out_valid.
//
//   Optional feature macro: BSMAC_FRAME_ERR_EN
//     When defined, adds output frame_err. It is a one-cycle pulse raised on
//     the edge that detects an aborted frame (input_valid dropped mid-frame).
//
// Ports
//   clk             in   1      rising-edge clock
//   rst             in   1      asynchronous active-high reset
//   input_valid     in   1      beat qualifier
//   Input_1..32     in   4 ea   unsigned lane partial products
//   frame_err       out  1      abort pulse (BSMAC_FRAME_ERR_EN only)
//   out_valid       out  1      one-cycle result strobe
//   Output          out  13     weighted sum, 0 whenever out_valid=0
module bitserial_mac_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic        input_valid,
    input  logic [3:0]  Input_1,
    input  logic [3:0]  Input_2,
    input  logic [3:0]  Input_3,
    input  logic [3:0]  Input_4,
    input  logic [3:0]  Input_5,
    input  logic [3:0]  Input_6,
    input  logic [3:0]  Input_7,
    input  logic [3:0]  Input_8,
    input  logic [3:0]  Input_9,
    input  logic [3:0]  Input_10,
    input  logic [3:0]  Input_11,
    input  logic [3:0]  Input_12,
    input  logic [3:0]  Input_13,
    input  logic [3:0]  Input_14,
    input  logic [3:0]  Input_15,
    input  logic [3:0]  Input_16,
    input  logic [3:0]  Input_17,
    input  logic [3:0]  Input_18,
    input  logic [3:0]  Input_19,
    input  logic [3:0]  Input_20,
    input  logic [3:0]  Input_21,
    input  logic [3:0]  Input_22,
    input  logic [3:0]  Input_23,
    input  logic [3:0]  Input_24,
    input  logic [3:0]  Input_25,
    input  logic [3:0]  Input_26,
    input  logic [3:0]  Input_27,
    input  logic [3:0]  Input_28,
    input  logic [3:0]  Input_29,
    input  logic [3:0]  Input_30,
    input  logic [3:0]  Input_31,
    input  logic [3:0]  Input_32,
`ifdef BSMAC_FRAME_ERR_EN
    output logic        frame_err,
`endif
    output logic        out_valid,
    output logic [12:0] Output
);

    localparam int unsigned N_IN  = 32;
    localparam int unsigned IN_W  = 4;
    localparam int unsigned BEATS = 4;
    // OUT_W covers N_IN*(2^IN_W-1)*(2^BEATS-1) = 7200, so the accumulator cannot overflow
    localparam int unsigned OUT_W = 13;
    localparam int unsigned COL_W = 9;   // holds N_IN*(2^IN_W-1) = 480
    localparam int unsigned CNT_W = $clog2(BEATS);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [COL_W-1:0]   col_sum_q, col_sum_d;
    logic               s1_vld_q, s1_vld_d;
    logic               s1_first_q, s1_first_d;
    logic               s1_last_q, s1_last_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;

    logic [IN_W-1:0]    lane_c [N_IN];
    logic [COL_W-1:0]   lane_sum_c;

    // Gather the individually named lane ports into an array
    assign lane_c[0]  = Input_1;
    assign lane_c[1]  = Input_2;
    assign lane_c[2]  = Input_3;
    assign lane_c[3]  = Input_4;
    assign lane_c[4]  = Input_5;
    assign lane_c[5]  = Input_6;
    assign lane_c[6]  = Input_7;
    assign lane_c[7]  = Input_8;
    assign lane_c[8]  = Input_9;
    assign lane_c[9]  = Input_10;
    assign lane_c[10] = Input_11;
    assign lane_c[11] = Input_12;
    assign lane_c[12] = Input_13;
    assign lane_c[13] = Input_14;
    assign lane_c[14] = Input_15;
    assign lane_c[15] = Input_16;
    assign lane_c[16] = Input_17;
    assign lane_c[17] = Input_18;
    assign lane_c[18] = Input_19;
    assign lane_c[19] = Input_20;
    assign lane_c[20] = Input_21;
    assign lane_c[21] = Input_22;
    assign lane_c[22] = Input_23;
    assign lane_c[23] = Input_24;
    assign lane_c[24] = Input_25;
    assign lane_c[25] = Input_26;
    assign lane_c[26] = Input_27;
    assign lane_c[27] = Input_28;
    assign lane_c[28] = Input_29;
    assign lane_c[29] = Input_30;
    assign lane_c[30] = Input_31;
    assign lane_c[31] = Input_32;

    // Column sum of all lanes for the current beat
    always_comb begin
        lane_sum_c = '0;
        for (int k = 0; k < N_IN; k++) begin
            lane_sum_c = lane_sum_c + COL_W'(lane_c[k]);
        end
    end

    // Beat tracking: IDLE means beat_cnt==0; dropping input_valid in RECV aborts the frame
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (input_valid) begin
                    beat_cnt_d = CNT_W'(1);
                    state_d    = RECV;
                end
            end
            RECV: begin
                if (!input_valid) begin
                    beat_cnt_d = '0;
                    state_d    = IDLE;
                end else if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
                    beat_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                beat_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    // Stage 1 captures the lanes only on valid beats, so idle-cycle X never enters the pipe
    always_comb begin
        s1_vld_d   = input_valid;
        col_sum_d  = col_sum_q;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        if (input_valid) begin
            col_sum_d  = lane_sum_c;
            s1_first_d = (beat_cnt_q == '0);
            s1_last_d  = (beat_cnt_q == CNT_W'(BEATS - 1));
        end
    end

    // Stage 2 shift-accumulates; the result register takes the final acc value directly
    always_comb begin
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        if (s1_vld_q) begin
            acc_d = (s1_first_q ? OUT_W'(0) : (acc_q << 1)) + OUT_W'(col_sum_q);
        end
        if (s1_vld_q && s1_last_q) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_d;
        end
    end

    // State and pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            col_sum_q   <= '0;
            s1_vld_q    <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            col_sum_q   <= col_sum_d;
            s1_vld_q    <= s1_vld_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Output    = out_data_q;

`ifdef BSMAC_FRAME_ERR_EN
    logic frame_err_q, frame_err_d;

    // One-cycle pulse when a frame is cut short
    always_comb begin
        frame_err_d = (state_q == RECV) && !input_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_bitserial_mac_acc.sv
module tb_bitserial_mac_acc;

    logic        clk;
    logic        rst;
    logic        input_valid;
    logic [3:0]  lanes [32];
    logic        out_valid;
    logic [12:0] Output;
`ifdef BSMAC_FRAME_ERR_EN
    logic        frame_err;
`endif

    int n_tests;
    int n_fail;

    bitserial_mac_acc dut (
        .clk(clk), .rst(rst), .input_valid(input_valid),
        .Input_1(lanes[0]),   .Input_2(lanes[1]),   .Input_3(lanes[2]),   .Input_4(lanes[3]),
        .Input_5(lanes[4]),   .Input_6(lanes[5]),   .Input_7(lanes[6]),   .Input_8(lanes[7]),
        .Input_9(lanes[8]),   .Input_10(lanes[9]),  .Input_11(lanes[10]), .Input_12(lanes[11]),
        .Input_13(lanes[12]), .Input_14(lanes[13]), .Input_15(lanes[14]), .Input_16(lanes[15]),
        .Input_17(lanes[16]), .Input_18(lanes[17]), .Input_19(lanes[18]), .Input_20(lanes[19]),
        .Input_21(lanes[20]), .Input_22(lanes[21]), .Input_23(lanes[22]), .Input_24(lanes[23]),
        .Input_25(lanes[24]), .Input_26(lanes[25]), .Input_27(lanes[26]), .Input_28(lanes[27]),
        .Input_29(lanes[28]), .Input_30(lanes[29]), .Input_31(lanes[30]), .Input_32(lanes[31]),
`ifdef BSMAC_FRAME_ERR_EN
        .frame_err(frame_err),
`endif
        .out_valid(out_valid), .Output(Output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one beat (lane 0 = l0, every other lane = rest) across the next rising edge
    task automatic set_beat(input logic [3:0] l0, input logic [3:0] rest);
        lanes[0] = l0;
        for (int k = 1; k < 32; k++) lanes[k] = rest;
        input_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        input_valid = 1'b0;
        for (int k = 0; k < 32; k++) lanes[k] = 'x;
        @(negedge clk);
    endtask

    // Called on the negedge right after the last beat was sampled
    task automatic expect_result(input string tag, input logic [31:0] exp);
        input_valid = 1'b0;
        for (int k = 0; k < 32; k++) lanes[k] = 'x;
        check({tag, "_pre_vld"}, 32'(out_valid), 32'd0);
        check({tag, "_pre_out"}, 32'(Output), 32'd0);
        @(negedge clk);
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_out"}, 32'(Output), exp);
        @(negedge clk);
        check({tag, "_post_vld"}, 32'(out_valid), 32'd0);
        check({tag, "_post_out"}, 32'(Output), 32'd0);
    endtask

    initial begin
        logic [3:0]  rnd [4][32];
        int unsigned gold;

        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        input_valid = 1'b0;
        for (int k = 0; k < 32; k++) lanes[k] = 'x;
        repeat (2) @(negedge clk);
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_out", 32'(Output), 32'd0);
`ifdef BSMAC_FRAME_ERR_EN
        check("rst_ferr", 32'(frame_err), 32'd0);
`endif
        rst = 1'b0;
        idle_cycle();

        // 1: full-scale frame
        repeat (4) set_beat(4'd15, 4'd15);
        expect_result("t1_max", 32'd7200);

        // 2: all zero
        repeat (4) set_beat(4'd0, 4'd0);
        expect_result("t2_zero", 32'd0);

        // 3: single lane, MSB beat then LSB beat
        set_beat(4'd1, 4'd0);
        repeat (3) set_beat(4'd0, 4'd0);
        expect_result("t3_msb", 32'd8);
        repeat (3) set_beat(4'd0, 4'd0);
        set_beat(4'd1, 4'd0);
        expect_result("t3_lsb", 32'd1);

        // 4: back-to-back frames, pulse 4 cycles apart
        for (int i = 0; i < 8; i++) begin
            if (i < 4) set_beat(4'd1, 4'd1);
            else       set_beat(4'd2, 4'd2);
            check($sformatf("t4_vld_%0d", i), 32'(out_valid), (i == 4) ? 32'd1 : 32'd0);
            if (i == 4) check("t4_out_a", 32'(Output), 32'd480);
        end
        expect_result("t4_b", 32'd960);

        // 5: aborted 2-beat frame followed by a full frame
        set_beat(4'd15, 4'd15);
        set_beat(4'd15, 4'd15);
        idle_cycle();
        check("t5_abort_vld", 32'(out_valid), 32'd0);
`ifdef BSMAC_FRAME_ERR_EN
        check("t5_ferr_hi", 32'(frame_err), 32'd1);
`endif
        for (int i = 0; i < 4; i++) begin
            set_beat(4'd1, 4'd1);
            check($sformatf("t5_vld_%0d", i), 32'(out_valid), 32'd0);
`ifdef BSMAC_FRAME_ERR_EN
            check($sformatf("t5_ferr_lo_%0d", i), 32'(frame_err), 32'd0);
`endif
        end
        expect_result("t5_after", 32'd480);

        // 6a: reset cancels a pulse that is already up
        repeat (4) set_beat(4'd15, 4'd15);
        idle_cycle();
        check("t6a_vld_up", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("t6a_vld_rst", 32'(out_valid), 32'd0);
        check("t6a_out_rst", 32'(Output), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();

        // 6b: reset between beat 2 and beat 3 loses the frame
        repeat (3) set_beat(4'd15, 4'd15);
        input_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t6b_vld_rst", 32'(out_valid), 32'd0);
        check("t6b_out_rst", 32'(Output), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle_cycle();
            check($sformatf("t6b_quiet_%0d", i), 32'(out_valid), 32'd0);
        end

        // 6c: random frame against the weighted golden sum
        gold = 0;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 32; k++) begin
                rnd[b][k] = 4'($urandom_range(0, 15));
                gold += int'(rnd[b][k]) * (1 << (3 - b));
            end
        end
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 32; k++) lanes[k] = rnd[b][k];
            input_valid = 1'b1;
            @(negedge clk);
        end
        expect_result("t6c_rand", 32'(gold));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
